// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch sequencer.
// Holds the FSM encoding, the datapath width and the reset/trap vector defaults.
package fetch_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] TRAP_VEC_DEFAULT = 32'h0000_0010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

    function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: picks the next PC, runs the imem request/response
// handshake and presents one fetched word at a time to decode.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [XLEN-1:0] TRAP_VEC = TRAP_VEC_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [XLEN-1:0]   pc,
    output logic [XLEN-1:0]   pc_next,
    output logic              imem_req,
    output logic [XLEN-1:0]   imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [XLEN-1:0]   imem_rdata,
    output logic              instr_valid,
    output logic [XLEN-1:0]   instr,
    output logic [XLEN-1:0]   instr_pc,
    input  logic              instr_ready,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_target,
    input  logic              trap,
    output logic              misalign,
    output fetch_state_t      state
);

    // Handshakes: a transfer happens in a cycle where valid and ready (imem_req/imem_gnt,
    // instr_valid/instr_ready) are both high; valid never depends on ready, and a
    // trap or redirect withdraws valid/req in the same cycle so nothing transfers.

    fetch_state_t state_q, state_d;
    logic         drop_q, drop_d;
    logic         kill;
    logic         redirect_mis;
    logic         handoff;
    logic         capture;

    assign kill         = trap | redirect_valid;
    assign redirect_mis = redirect_valid & is_misaligned(redirect_target);
    assign imem_addr    = pc;
    assign state        = state_q;

    always_comb begin
        state_d     = state_q;
        drop_d      = drop_q;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        capture     = 1'b0;
        handoff     = 1'b0;

        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                imem_req = ~kill;
                if (imem_req && imem_gnt) state_d = WAIT;
            end
            WAIT: begin
                // A response that belongs to a squashed path is thrown away here.
                if (imem_rvalid) begin
                    drop_d = 1'b0;
                    if (drop_q || kill) begin
                        state_d = REQ;
                    end else begin
                        capture = 1'b1;
                        state_d = HOLD;
                    end
                end else if (kill) begin
                    drop_d = 1'b1;
                end
            end
            HOLD: begin
                instr_valid = ~kill;
                handoff     = instr_valid & instr_ready;
                if (kill || handoff) state_d = REQ;
            end
            default: state_d = IDLE;
        endcase

        if (trap)                pc_next = TRAP_VEC;
        else if (redirect_mis)   pc_next = TRAP_VEC;
        else if (redirect_valid) pc_next = redirect_target;
        else if (handoff)        pc_next = pc + 32'd4;
        else                     pc_next = pc;

        if (!reset) begin
            pc_next     = RESET_PC;
            imem_req    = 1'b0;
            instr_valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            drop_q   <= 1'b0;
            instr    <= '0;
            instr_pc <= '0;
            misalign <= 1'b0;
        end else begin
            state_q  <= state_d;
            drop_q   <= drop_d;
            // A trap outranks the redirect, so its misaligned target raises no pulse.
            misalign <= redirect_mis & ~trap;
            if (capture) begin
                instr    <= imem_rdata;
                instr_pc <= pc;
            end
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios followed by a randomized run, with the PC
// register and instruction memory modelled here and an in-order instruction-stream model.
module tb_fetch_ctrl;
    import fetch_pkg::*;

    localparam logic [31:0] RST_PC     = 32'h0000_0000;
    localparam logic [31:0] TVEC       = 32'h0000_0010;
    localparam int          HANG_LIMIT = 150;

    logic        clk;
    logic        reset;
    logic [31:0] pc, pc_next, imem_addr, imem_rdata, instr, instr_pc, redirect_target;
    logic        imem_req, imem_gnt, imem_rvalid, instr_valid, instr_ready;
    logic        redirect_valid, trap, misalign;
    fetch_state_t state;

    int checks = 0;
    int errors = 0;

    // memory model
    logic        mem_busy;
    int          mem_cnt;
    logic [31:0] mem_addr;
    int          lat_min, lat_max, gnt_pct;
    logic        fixed_data;

    // reference model
    logic [31:0] exp_pc;
    logic        mis_prev;
    int          since_hand;
    int          r;
    logic [31:0] tgt;

    fetch_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .pc              (pc),
        .pc_next         (pc_next),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_gnt        (imem_gnt),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .instr_valid     (instr_valid),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .instr_ready     (instr_ready),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .trap            (trap),
        .misalign        (misalign),
        .state           (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk) pc <= pc_next;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return fixed_data ? 32'h0000_0013 : ((a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Sample at the falling edge and run the generic model checks for this cycle.
    task automatic settle();
        logic [31:0] exp_next;
        logic        hand;
        @(negedge clk);
        chk("imem_addr_eq_pc", imem_addr, pc);
        chk("misalign_pulse", {31'b0, misalign}, {31'b0, mis_prev});
        if (!reset) begin
            chk("rst_pc_next", pc_next, RST_PC);
            chk("rst_req", {31'b0, imem_req}, 32'd0);
            chk("rst_valid", {31'b0, instr_valid}, 32'd0);
            exp_pc     = RST_PC;
            mis_prev   = 1'b0;
            since_hand = 0;
        end else begin
            hand = instr_valid && instr_ready;
            if (trap)                                exp_next = TVEC;
            else if (redirect_valid)                 exp_next = (redirect_target[1:0] != 2'b00) ? TVEC : redirect_target;
            else if (hand)                           exp_next = pc + 32'd4;
            else                                     exp_next = pc;
            chk("pc_next", pc_next, exp_next);
            if (trap || redirect_valid) begin
                chk("kill_req", {31'b0, imem_req}, 32'd0);
                chk("kill_valid", {31'b0, instr_valid}, 32'd0);
            end
            if (hand) begin
                chk("hand_pc", instr_pc, exp_pc);
                chk("hand_word", instr, word_of(exp_pc));
                exp_pc     = exp_pc + 32'd4;
                since_hand = 0;
            end else begin
                since_hand++;
            end
            if (trap || redirect_valid) exp_pc = exp_next;
            mis_prev = redirect_valid && !trap && (redirect_target[1:0] != 2'b00);
            checks++;
            assert (since_hand <= HANG_LIMIT) else begin
                errors++;
                $error("FAIL liveness cycles_without_handoff=%0d limit=%0d", since_hand, HANG_LIMIT);
                since_hand = 0;
            end
        end
    endtask

    // Memory bookkeeping for this cycle, then advance to just after the next rising edge.
    task automatic tick();
        if (imem_rvalid) mem_busy = 1'b0;
        if (reset && imem_req && imem_gnt) begin
            mem_busy = 1'b1;
            mem_addr = imem_addr;
            mem_cnt  = int'($urandom_range(lat_max, lat_min));
        end
        @(posedge clk);
        #1;
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (mem_busy) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = word_of(mem_addr);
            end
        end
        imem_gnt = !mem_busy && ($urandom_range(99, 0) < gnt_pct);
    endtask

    task automatic wait_for_state(input fetch_state_t s, input string tag);
        int n;
        n = 0;
        settle();
        while (state !== s && n < 40) begin
            tick();
            settle();
            n++;
        end
        chk(tag, 32'(state), 32'(s));
    endtask

    initial begin
        reset = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0; trap = 1'b0;
        redirect_target = '0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        lat_min = 1; lat_max = 1; gnt_pct = 100; fixed_data = 1'b1;
        mem_busy = 1'b0; mem_cnt = 0; mem_addr = '0;
        exp_pc = RST_PC; mis_prev = 1'b0; since_hand = 0;

        // reset held low for three cycles
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("rst_state", 32'(state), 32'(IDLE));
            tick();
        end

        // release: IDLE on cycle 1, first request on cycle 2
        reset = 1'b1; instr_ready = 1'b1;
        settle();
        chk("c1_req", {31'b0, imem_req}, 32'd0);
        chk("c1_state", 32'(state), 32'(IDLE));
        tick();
        settle();
        chk("c2_req", {31'b0, imem_req}, 32'd1);
        chk("c2_addr", imem_addr, 32'h0);
        tick();

        // sequential fetch: one instruction every 3 cycles
        for (int c = 3; c <= 13; c++) begin
            settle();
            chk($sformatf("seq_valid_c%0d", c), {31'b0, instr_valid}, {31'b0, (c % 3 == 1)});
            if (c % 3 == 1) begin
                chk($sformatf("seq_instr_pc_c%0d", c), instr_pc, 32'((c - 4) / 3 * 4));
                chk($sformatf("seq_instr_c%0d", c), instr, 32'h0000_0013);
            end
            tick();
        end

        // redirect while WAIT, before the response
        settle();
        chk("c14_req", {31'b0, imem_req}, 32'd1);
        chk("c14_addr", imem_addr, 32'h10);
        lat_min = 3; lat_max = 3;
        tick();
        redirect_valid = 1'b1; redirect_target = 32'h100;
        settle();
        chk("rdw_state", 32'(state), 32'(WAIT));
        chk("rdw_pc_next", pc_next, 32'h100);
        lat_min = 1; lat_max = 1;
        tick();
        redirect_valid = 1'b0;
        settle();
        tick();
        settle();
        chk("rdw_state_rvalid", 32'(state), 32'(WAIT));
        chk("rdw_no_valid", {31'b0, instr_valid}, 32'd0);
        tick();
        settle();
        chk("rdw_back_to_req", 32'(state), 32'(REQ));
        chk("rdw_valid_after", {31'b0, instr_valid}, 32'd0);
        chk("rdw_addr", imem_addr, 32'h100);
        tick();
        settle();
        tick();

        // redirect together with instr_ready in HOLD
        redirect_valid = 1'b1; redirect_target = 32'h40;
        settle();
        chk("rdh_state", 32'(state), 32'(HOLD));
        chk("rdh_valid", {31'b0, instr_valid}, 32'd0);
        chk("rdh_pc_next", pc_next, 32'h40);
        tick();
        redirect_valid = 1'b0;
        settle();
        chk("rdh_req_state", 32'(state), 32'(REQ));
        chk("rdh_addr", imem_addr, 32'h40);
        tick();
        settle();
        tick();
        settle();
        chk("rdh_valid2", {31'b0, instr_valid}, 32'd1);
        chk("rdh_instr_pc", instr_pc, 32'h40);
        tick();

        // misaligned redirect, then trap with redirect
        redirect_valid = 1'b1; redirect_target = 32'h102;
        settle();
        chk("mis_pc_next", pc_next, TVEC);
        chk("mis_req", {31'b0, imem_req}, 32'd0);
        chk("mis_pre", {31'b0, misalign}, 32'd0);
        tick();
        redirect_valid = 1'b0;
        settle();
        chk("mis_pulse", {31'b0, misalign}, 32'd1);
        chk("mis_addr", imem_addr, TVEC);
        tick();
        trap = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h200;
        settle();
        chk("mis_clear", {31'b0, misalign}, 32'd0);
        chk("trap_pc_next", pc_next, TVEC);
        tick();
        trap = 1'b0; redirect_valid = 1'b0;
        settle();
        chk("trap_state", 32'(state), 32'(REQ));
        chk("trap_addr", imem_addr, TVEC);
        chk("trap_no_pulse", {31'b0, misalign}, 32'd0);
        tick();

        // wrap from the top of the address space
        redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
        settle();
        tick();
        redirect_valid = 1'b0;
        wait_for_state(HOLD, "wrap_hold");
        chk("wrap_instr_pc", instr_pc, 32'hFFFF_FFFC);
        chk("wrap_pc_next", pc_next, 32'h0);
        tick();
        settle();
        chk("wrap_addr", imem_addr, 32'h0);
        chk("wrap_req", {31'b0, imem_req}, 32'd1);
        lat_min = 3; lat_max = 3;
        tick();

        // reset in WAIT, late response lands in IDLE
        settle();
        chk("mr_wait", 32'(state), 32'(WAIT));
        tick();
        reset = 1'b0;
        settle();
        tick();
        reset = 1'b1; lat_min = 1; lat_max = 1;
        settle();
        chk("mr_idle", 32'(state), 32'(IDLE));
        chk("mr_valid_idle", {31'b0, instr_valid}, 32'd0);
        tick();
        settle();
        chk("mr_req", 32'(state), 32'(REQ));
        chk("mr_addr", imem_addr, RST_PC);
        tick();
        wait_for_state(HOLD, "mr_hold");
        chk("mr_instr_pc", instr_pc, RST_PC);
        tick();

        // randomized run against the stream model
        fixed_data = 1'b0; lat_min = 1; lat_max = 4; gnt_pct = 60;
        for (int i = 0; i < 1500; i++) begin
            instr_ready    = ($urandom_range(99, 0) < 75);
            r              = int'($urandom_range(99, 0));
            trap           = (r < 2);
            redirect_valid = (r == 0) || (r >= 2 && r < 7);
            tgt            = $urandom;
            if (trap || $urandom_range(3, 0) != 0) tgt[1:0] = 2'b00;
            redirect_target = tgt;
            reset          = ($urandom_range(199, 0) != 0);
            settle();
            tick();
        end
        trap = 1'b0; redirect_valid = 1'b0; reset = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer that drives the `pc_next` input of the PC register and owns the instruction-memory request handshake. It decides each cycle whether the PC holds, advances by 4, or jumps to a redirect or trap target. It fetches the word at the current PC and hands it to decode through a valid/ready interface, discarding wrong-path responses after a redirect. It sits between the PC register, instruction memory and decode.

## Interface
- `RESET_PC`, default `32'h0000_0000`: value forced onto `pc_next` while reset is asserted.
- `TRAP_VEC`, default `32'h0000_0010`: target on `trap` or on a misaligned redirect.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `pc`  in  32  current PC from the PC register.
- `pc_next`  out  32  next PC; the PC register loads it unconditionally every cycle.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address; always equals `pc`.
- `imem_gnt`  in  1  request accepted this cycle.
- `imem_rvalid`  in  1  response data valid.
- `imem_rdata`  in  32  response word.
- `instr_valid`  out  1  instruction available to decode.
- `instr`  out  32  held instruction word.
- `instr_pc`  out  32  PC of `instr`.
- `instr_ready`  in  1  decode accepts `instr`.
- `redirect_valid`  in  1  branch/jump redirect from execute.
- `redirect_target`  in  32  redirect address.
- `trap`  in  1  trap request; highest priority.
- `misalign`  out  1  one-cycle pulse; a redirect target had `[1:0] != 0`.

## Operation
- FSM states are IDLE, REQ, WAIT and HOLD. There is also a `drop` flag register.
- **Reset** (`reset == 0` at an edge): state becomes IDLE, `drop` = 0, `instr`/`instr_pc` = 0, `misalign` = 0.
  - While `reset` is low, `pc_next` = `RESET_PC`, `imem_req` = 0 and `instr_valid` = 0.
  - Reset wins over every other input, including mid-transaction. Any outstanding response arriving after reset deasserts is ignored until state reaches REQ.
- **IDLE**: go to REQ next cycle; `pc_next` = `pc`.
- **REQ**: `imem_req` = 1 unless `trap` or `redirect_valid` is high this cycle.
  - On `imem_gnt` with `imem_req` = 1, go to WAIT.
  - Otherwise stay in REQ.
- **WAIT**: on `imem_rvalid`:
  - If `drop` = 0, capture `imem_rdata` into `instr` and `pc` into `instr_pc`, then go to HOLD.
  - If `drop` = 1, discard the response, clear `drop`, and go to REQ.
- **HOLD**: `instr_valid` = 1 unless `trap` or `redirect_valid` is high this cycle.
  - On `instr_valid && instr_ready`, `pc_next` = `pc + 4` and go to REQ.
- **pc_next priority**, applied in every non-reset state:
  1. `trap`: `pc_next` = `TRAP_VEC`.
  2. `redirect_valid` with `redirect_target[1:0] != 0`: `pc_next` = `TRAP_VEC`, and `misalign` pulses next cycle.
  3. `redirect_valid` with an aligned target: `pc_next` = `redirect_target`.
  4. Handoff in HOLD: `pc_next` = `pc + 4`.
  5. Otherwise `pc_next` = `pc` (hold).
- **Effect of `trap` or `redirect_valid` by state:**
  - REQ: stay in REQ. No grant can occur because the request is suppressed.
  - WAIT without `imem_rvalid`: set `drop`.
  - WAIT with `imem_rvalid` in the same cycle: discard the word and go to REQ.
  - HOLD: go to REQ. A simultaneous `instr_ready` is not a handoff.
  - IDLE: no state effect.
- **Arithmetic**: `pc + 4` is 32-bit modulo, so `32'hFFFF_FFFC` wraps to 0. There is no alignment check on sequential PCs.

## Timing
- `pc_next`, `imem_req` and `instr_valid` are combinational from state and the current inputs.
- `instr`, `instr_pc`, `drop` and `misalign` are registered.
- `imem_rvalid` must come no earlier than the cycle after `imem_gnt`. At most one request is outstanding.
- Best case is REQ (grant) → WAIT (rvalid) → HOLD (ready): 3 cycles per instruction. After reset deasserts, the first request appears on cycle 2 (IDLE occupies cycle 1).
- Throughput is one instruction per 3 cycles. No prefetch.

## Structure
- Shared package `fetch_pkg` holds:
  - the `fetch_state_t` enum (IDLE, REQ, WAIT, HOLD);
  - `XLEN` = 32;
  - the defaults for `RESET_PC` and `TRAP_VEC`.
- Single flat module with no sub-modules. The PC register is instantiated beside it at the top level, with its `pc`/`pc_next` ports wired to this block.

## Test plan
- **Reset**: hold `reset` low 3 cycles, then high.
  - During reset: `pc_next` = `RESET_PC`, `imem_req` = 0, `instr_valid` = 0.
  - First `imem_req` with `imem_addr` = 0 on cycle 2 after release.
- **Sequential fetch**: memory with 1-cycle grant and 1-cycle rvalid returning `32'h0000_0013`; decode always ready.
  - `instr_pc` steps 0, 4, 8, 12, one instruction every 3 cycles.
- **Redirect in WAIT**: assert `redirect_valid` with target `32'h100` before rvalid.
  - Returned word is discarded and `instr_valid` stays 0.
  - Next `imem_addr` = `32'h100`.
- **Redirect with `instr_ready` in HOLD**: target `32'h40`.
  - No handoff; `pc_next` = `32'h40`.
  - Following `instr_pc` = `32'h40`.
- **Misaligned and trap**: redirect to `32'h102` → `pc_next` = `TRAP_VEC` and a one-cycle `misalign` pulse. Then assert `trap` and `redirect_valid` together → `TRAP_VEC` wins.
- **Wrap and mid-operation reset**:
  - Start at `32'hFFFF_FFFC`: next fetch address is 0.
  - Assert `reset` in WAIT: state returns to IDLE and the late rvalid is ignored.
